// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring integer divider: one quotient bit per clock behind a start/done handshake.
// Optional signed mode is enabled by defining DIV_SIGNED_EN, which adds the signed_op_i port.
module seq_restoring_divider #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
`ifdef DIV_SIGNED_EN
    input  logic             signed_op_i,
`endif
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dbz_q, dbz_d;

    logic               ready;
    logic               accept;
    logic               div_zero;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   shifted;
    logic [WIDTH:0]     trial;
    logic               borrow;
    logic [WIDTH-1:0]   q_next, r_next;
    logic [WIDTH-1:0]   q_fin, r_fin;

`ifdef DIV_SIGNED_EN
    logic neg_q_q, neg_q_d;
    logic neg_r_q, neg_r_d;
    logic a_neg, b_neg;
`endif

    assign ready    = (state_q == StIdle) || (state_q == StDone);
    assign accept   = start_i && ready;
    assign div_zero = (divisor_i == '0);

    // Operand magnitudes taken at accept; sign is reapplied when results are loaded.
`ifdef DIV_SIGNED_EN
    always_comb begin
        a_neg   = signed_op_i && dividend_i[WIDTH-1];
        b_neg   = signed_op_i && divisor_i[WIDTH-1];
        a_mag   = a_neg ? (~dividend_i + 1'b1) : dividend_i;
        b_mag   = b_neg ? (~divisor_i + 1'b1) : divisor_i;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        if (accept) begin
            neg_q_d = a_neg ^ b_neg;
            neg_r_d = a_neg;
        end
    end
`else
    assign a_mag = dividend_i;
    assign b_mag = divisor_i;
`endif

    // R never has its top bit set before a shift, so dropping R[WIDTH-1] loses nothing.
    assign shifted = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    assign trial   = {1'b0, shifted} - {1'b0, dvs_q};
    assign borrow  = trial[WIDTH];
    assign q_next  = {quo_q[WIDTH-2:0], ~borrow};
    assign r_next  = borrow ? shifted : trial[WIDTH-1:0];

`ifdef DIV_SIGNED_EN
    assign q_fin = neg_q_q ? (~q_next + 1'b1) : q_next;
    assign r_fin = neg_r_q ? (~r_next + 1'b1) : r_next;
`else
    assign q_fin = q_next;
    assign r_fin = r_next;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = div_zero ? StDone : StCalc;
            StCalc: if (cnt_q == CNT_W'(1)) state_d = StDone;
            StDone: state_d = accept ? (div_zero ? StDone : StCalc) : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o        = (state_q == StCalc);
        done_o        = (state_q == StDone);
        ready_o       = ready;
        quotient_o    = quotient_q;
        remainder_o   = remainder_q;
        div_by_zero_o = dbz_q;
    end

    always_comb begin
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        if (accept) begin
            quo_d = a_mag;
            dvs_d = b_mag;
            rem_d = '0;
            cnt_d = CNT_W'(WIDTH);
            dbz_d = 1'b0;
            if (div_zero) begin
                quotient_d  = '1;
                remainder_d = dividend_i;
                dbz_d       = 1'b1;
            end
        end else if (state_q == StCalc) begin
            rem_d = r_next;
            quo_d = q_next;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                quotient_d  = q_fin;
                remainder_d = r_fin;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef DIV_SIGNED_EN
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Randomized and directed bench for seq_restoring_divider against a plain-arithmetic model.
module tb_seq_restoring_divider;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         signed_op;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dbz;

    int passed = 0;
    int total  = 0;

    seq_restoring_divider #(.WIDTH(W), .CNT_W(6)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .dividend_i   (dividend),
        .divisor_i    (divisor),
`ifdef DIV_SIGNED_EN
        .signed_op_i  (signed_op),
`endif
        .ready_o      (ready),
        .busy_o       (busy),
        .done_o       (done),
        .quotient_o   (quotient),
        .remainder_o  (remainder),
        .div_by_zero_o(dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        logic signed [W-1:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    // Drive one start pulse; returns just after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        signed_op = s;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // lat = clock edges after the accepting edge until done is seen.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 200) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit s, input int lat);
        logic [W-1:0] eq, er;
        int el;
        ref_div(a, b, s, eq, er);
        el = (b == 0) ? 0 : W;
        total++;
        if (quotient !== eq) $display("FAIL %s quotient: got %h want %h", name, quotient, eq);
        else passed++;
        total++;
        if (remainder !== er) $display("FAIL %s remainder: got %h want %h", name, remainder, er);
        else passed++;
        total++;
        if (dbz !== (b == 0)) $display("FAIL %s div_by_zero: got %b want %b", name, dbz, b == 0);
        else passed++;
        total++;
        if (lat !== el) $display("FAIL %s latency: got %0d want %0d", name, lat, el);
        else passed++;
    endtask

    task automatic test_reset();
        total++;
        if ({ready, busy, done, dbz} !== 4'b1000 || quotient !== 0 || remainder !== 0)
            $display("FAIL reset outputs: got rdy=%b busy=%b done=%b dbz=%b q=%h r=%h want 1 0 0 0 0 0",
                     ready, busy, done, dbz, quotient, remainder);
        else passed++;
    endtask

    task automatic test_basic();
        int lat, bc;
        issue(100, 7, 1'b0);
        wait_done(lat, bc);
        check_op("basic_100_7", 100, 7, 1'b0, lat);
        total++;
        if (bc !== W) $display("FAIL basic busy_cycles: got %0d want %0d", bc, W);
        else passed++;
    endtask

    task automatic test_zero_divisor();
        int lat, bc;
        issue(5, 0, 1'b0);
        wait_done(lat, bc);
        check_op("zero_div_5_0", 5, 0, 1'b0, lat);
        total++;
        if (bc !== 0) $display("FAIL zero_div busy_cycles: got %0d want 0", bc);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        issue(32'hFFFF_FFFF, 1, 1'b0);
        wait_done(lat, bc);
        check_op("ext_max_1", 32'hFFFF_FFFF, 1, 1'b0, lat);
        // Start raised while still in DONE must be accepted on the next edge.
        issue(3, 32'hFFFF_FFFF, 1'b0);
        wait_done(lat, bc);
        check_op("b2b_3_max", 3, 32'hFFFF_FFFF, 1'b0, lat);
    endtask

    task automatic test_protocol();
        int lat, bc, lat2;
        logic [W-1:0] hq, hr;
        issue(100, 7, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        issue(50, 5, 1'b0);
        wait_done(lat2, bc);
        lat = lat2 + 6;
        check_op("ignored_start", 100, 7, 1'b0, lat);
        hq = quotient;
        hr = remainder;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (quotient !== hq || remainder !== hr || done !== 1'b0 || ready !== 1'b1)
                $display("FAIL hold cycle %0d: got q=%h r=%h done=%b rdy=%b want q=%h r=%h done=0 rdy=1",
                         i, quotient, remainder, done, ready, hq, hr);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, bc;
        issue(1000, 3, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({ready, busy, done, dbz} !== 4'b1000 || quotient !== 0 || remainder !== 0)
            $display("FAIL mid_reset outputs: got rdy=%b busy=%b done=%b dbz=%b q=%h r=%h want 1 0 0 0 0 0",
                     ready, busy, done, dbz, quotient, remainder);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        issue(1000, 3, 1'b0);
        wait_done(lat, bc);
        check_op("after_reset_1000_3", 1000, 3, 1'b0, lat);
    endtask

    task automatic test_random();
        int lat, bc;
        logic [W-1:0] a, b;
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            case (i % 4)
                0: b = $urandom;
                1: b = $urandom_range(1, 255);
                2: b = a >> $urandom_range(0, 8);
                default: b = (i == 7) ? 0 : a + $urandom_range(1, 100);
            endcase
            if (i == 3) a = 0;
            issue(a, b, 1'b0);
            wait_done(lat, bc);
            check_op("random", a, b, 1'b0, lat);
        end
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed();
        int lat, bc;
        logic [W-1:0] a, b;
        issue(-7, 2, 1'b1);
        wait_done(lat, bc);
        check_op("signed_m7_2", -7, 2, 1'b1, lat);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done(lat, bc);
        check_op("signed_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat);
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = (i == 5) ? 0 : $urandom >> $urandom_range(0, 28);
            if (i % 2 == 1) b = -b;
            issue(a, b, 1'b1);
            wait_done(lat, bc);
            check_op("signed_random", a, b, 1'b1, lat);
        end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        dividend  = '0;
        divisor   = '0;
        signed_op = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_basic();
        test_zero_divisor();
        test_back_to_back();
        test_protocol();
        test_reset_mid_op();
        test_random();
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
